// File: rtl/dnn_classify_ctrl.sv
// dnn_classify_ctrl
//
// Runs one inference on the sigmoid/mu-law engine per host request. The
// sequence is: soft-reset the engine, start it, wait for done, then step the
// engine output selector over every class. The argmax class and its score are
// returned to the host over a valid/ack handshake.
//
// Optional feature:
//   DNN_CTRL_TIMEOUT_EN  adds a WAIT watchdog. After TIMEOUT_CYCLES cycles in
//                        WAIT without done, the controller returns
//                        res_err=1, res_digit=4'hF and res_score=0.
//                        Without it, WAIT never times out and res_err stays 0.
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   req_i        host request (level, sampled only in IDLE)
//   busy_o       high whenever the FSM is not in IDLE
//   res_valid_o  result available, held until res_ack_i
//   res_ack_i    host consumes the result (sampled only while res_valid_o=1)
//   res_digit_o  argmax class index (4'hF on timeout)
//   res_score_o  signed engine output at res_digit_o
//   res_err_o    watchdog expired for this result
//   eng_reset_o  engine soft-reset pulse
//   eng_start_o  engine start pulse
//   eng_done_i   engine completion (level or pulse)
//   eng_idx_o    engine output select
//   eng_out_i    selected engine output (combinational from eng_idx_o)
//
// state   | meaning
// IDLE    | waiting for req
// CLR     | engine soft reset requested (pulse appears the following cycle)
// START   | engine start requested (pulse appears the following cycle)
// WAIT    | waiting for eng_done (optionally guarded by the watchdog)
// SCAN    | stepping eng_idx over all classes and tracking the maximum
// RESULT  | res_valid high until res_ack
module dnn_classify_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CLASSES    = 10,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    output logic                         busy_o,
    output logic                         res_valid_o,
    input  logic                         res_ack_i,
    output logic [3:0]                   res_digit_o,
    output logic signed [DATA_WIDTH-1:0] res_score_o,
    output logic                         res_err_o,
    output logic                         eng_reset_o,
    output logic                         eng_start_o,
    input  logic                         eng_done_i,
    output logic [3:0]                   eng_idx_o,
    input  logic signed [DATA_WIDTH-1:0] eng_out_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_START,
        ST_WAIT,
        ST_SCAN,
        ST_RESULT
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    state_t                         state_q, state_d;
    logic [3:0]                     idx_q, idx_d;
    logic [3:0]                     best_idx_q, best_idx_d;
    logic signed [DATA_WIDTH-1:0]   best_val_q, best_val_d;
    logic [3:0]                     res_digit_q, res_digit_d;
    logic signed [DATA_WIDTH-1:0]   res_score_q, res_score_d;
    logic                           res_err_q, res_err_d;
    logic                           busy_q, res_valid_q;
    logic                           eng_reset_q, eng_start_q;
    logic                           timeout_hit;

    logic                           take_new;
    logic [3:0]                     cand_idx;
    logic signed [DATA_WIDTH-1:0]   cand_val;

`ifdef DNN_CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Down-counter loaded while entering WAIT, so it reaches zero on the
    // last permitted WAIT cycle.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_START) begin
            wait_cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (state_q == ST_WAIT && wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == '0);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    // Index 0 always seeds the running best; afterwards only a strictly
    // greater value replaces it, so ties keep the lowest index.
    assign take_new = (idx_q == 4'd0) || (eng_out_i > best_val_q);
    assign cand_idx = take_new ? idx_q : best_idx_q;
    assign cand_val = take_new ? eng_out_i : best_val_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        res_digit_d = res_digit_q;
        res_score_d = res_score_q;
        res_err_d   = res_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done wins over a simultaneous watchdog expiry.
                if (eng_done_i) begin
                    state_d = ST_SCAN;
                    idx_d   = 4'd0;
                end else if (timeout_hit) begin
                    state_d     = ST_RESULT;
                    res_digit_d = 4'hF;
                    res_score_d = '0;
                    res_err_d   = 1'b1;
                end
            end
            ST_SCAN: begin
                best_idx_d = cand_idx;
                best_val_d = cand_val;
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_RESULT;
                    idx_d       = 4'd0;
                    res_digit_d = cand_idx;
                    res_score_d = cand_val;
                    res_err_d   = 1'b0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_RESULT: begin
                if (res_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // busy/res_valid follow the next state; the engine pulses follow the
    // current state, which places them one cycle after CLR/START is entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            best_idx_q  <= 4'd0;
            best_val_q  <= '0;
            res_digit_q <= 4'd0;
            res_score_q <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            eng_reset_q <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            res_digit_q <= res_digit_d;
            res_score_q <= res_score_d;
            res_err_q   <= res_err_d;
            busy_q      <= (state_d != ST_IDLE);
            res_valid_q <= (state_d == ST_RESULT);
            eng_reset_q <= (state_q == ST_CLR);
            eng_start_q <= (state_q == ST_START);
        end
    end

    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign res_digit_o = res_digit_q;
    assign res_score_o = res_score_q;
    assign res_err_o   = res_err_q;
    assign eng_reset_o = eng_reset_q;
    assign eng_start_o = eng_start_q;
    // idx_q is held at zero outside SCAN.
    assign eng_idx_o   = idx_q;

endmodule

// File: tb/tb_dnn_classify_ctrl.sv
module tb_dnn_classify_ctrl;

    localparam int DW = 8;
    localparam int NC = 10;
    localparam int TO = 100;

    typedef struct packed {
        logic [3:0]        digit;
        logic signed [7:0] score;
        logic              err;
    } exp_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 req_i = 1'b0;
    logic                 res_ack_i = 1'b0;
    logic                 eng_done_i;
    logic                 busy_o, res_valid_o, res_err_o, eng_reset_o, eng_start_o;
    logic [3:0]           res_digit_o, eng_idx_o;
    logic signed [DW-1:0] res_score_o, eng_out_i;

    always #5 clk_i = ~clk_i;

    dnn_classify_ctrl #(
        .DATA_WIDTH    (DW),
        .NUM_CLASSES   (NC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .busy_o      (busy_o),
        .res_valid_o (res_valid_o),
        .res_ack_i   (res_ack_i),
        .res_digit_o (res_digit_o),
        .res_score_o (res_score_o),
        .res_err_o   (res_err_o),
        .eng_reset_o (eng_reset_o),
        .eng_start_o (eng_start_o),
        .eng_done_i  (eng_done_i),
        .eng_idx_o   (eng_idx_o),
        .eng_out_i   (eng_out_i)
    );

    // engine model: done is a level that rises done_delay cycles after start
    // and stays high until the next soft reset
    logic signed [DW-1:0] eng_vals [NC];
    int done_delay = 50;
    bit never_done = 1'b0;
    bit kick = 1'b0;
    int eng_cnt;
    bit eng_run;

    always_comb begin
        eng_out_i = '0;
        if (eng_idx_o < 4'(NC)) eng_out_i = eng_vals[eng_idx_o];
    end

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eng_done_i <= 1'b0;
            eng_run    <= 1'b0;
            eng_cnt    <= 0;
        end else begin
            if (eng_reset_o) eng_done_i <= 1'b0;
            if (kick) eng_done_i <= 1'b1;
            if (eng_start_o) begin
                eng_done_i <= 1'b0;
                eng_run    <= !never_done;
                eng_cnt    <= done_delay;
            end else if (eng_run) begin
                if (eng_cnt <= 1) begin
                    eng_done_i <= 1'b1;
                    eng_run    <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model_result();
        exp_t r;
        r.digit = 4'd0;
        r.score = eng_vals[0];
        r.err   = 1'b0;
        for (int i = 1; i < NC; i++) begin
            if (eng_vals[i] > r.score) begin
                r.score = eng_vals[i];
                r.digit = 4'(i);
            end
        end
        return r;
    endfunction

    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // monitor: pulse counts, scan index sequence, result latency, scoreboard
    int n_rst_p = 0;
    int n_start_p = 0;
    int start_cyc = -1;
    int n_cyc = -1;
    bit armed = 1'b0;
    bit rv_prev = 1'b0;

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            armed     = 1'b0;
            n_cyc     = -1;
            n_rst_p   = 0;
            n_start_p = 0;
            rv_prev   = 1'b0;
        end else begin
            if (eng_reset_o) n_rst_p++;
            if (eng_start_o) begin
                n_start_p++;
                start_cyc = cyc;
                armed     = 1'b1;
                n_cyc     = -1;
            end else if (armed && eng_done_i) begin
                n_cyc = cyc + 1;
                armed = 1'b0;
            end
            if (n_cyc >= 0 && cyc >= n_cyc && cyc < n_cyc + NC)
                check_eq("scan_idx", eng_idx_o, cyc - n_cyc);
            if (res_valid_o && !rv_prev) begin
                if (n_cyc >= 0) check_eq("valid_latency", cyc, n_cyc + NC);
                check_eq("idx_after_scan", eng_idx_o, 0);
                check_eq("reset_pulses", n_rst_p, 1);
                check_eq("start_pulses", n_start_p, 1);
                check_eq("sb_depth", sb.size(), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("res_digit", res_digit_o, e.digit);
                    check_eq("res_score", res_score_o, e.score);
                    check_eq("res_err", res_err_o, e.err);
                end
                n_rst_p   = 0;
                n_start_p = 0;
                n_cyc     = -1;
            end
            rv_prev = res_valid_o;
        end
    end

    task automatic pulse_req();
        @(negedge clk_i);
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!res_valid_o && k < 2000) begin
            @(negedge clk_i);
            k++;
        end
        if (!res_valid_o) check_eq("valid_wait", res_valid_o, 1);
    endtask

    task automatic ack_it();
        @(negedge clk_i);
        res_ack_i = 1'b1;
        @(negedge clk_i);
        res_ack_i = 1'b0;
        check_eq("ack_valid", res_valid_o, 0);
        check_eq("ack_busy", busy_o, 0);
    endtask

    task automatic run_one(input int delay);
        exp_t e;
        e = model_result();
        sb.push_back(e);
        done_delay = delay;
        pulse_req();
        wait_valid();
        ack_it();
    endtask

    task automatic check_reset_vals();
        check_eq("rv_busy", busy_o, 0);
        check_eq("rv_valid", res_valid_o, 0);
        check_eq("rv_digit", res_digit_o, 0);
        check_eq("rv_score", res_score_o, 0);
        check_eq("rv_err", res_err_o, 0);
        check_eq("rv_eng_reset", eng_reset_o, 0);
        check_eq("rv_eng_start", eng_start_o, 0);
        check_eq("rv_eng_idx", eng_idx_o, 0);
    endtask

    task automatic rand_vals();
        for (int j = 0; j < NC; j++) eng_vals[j] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        exp_t e;
        int k;
        int c_rise;
        logic signed [7:0] va [NC];

        for (int i = 0; i < NC; i++) eng_vals[i] = '0;
        repeat (3) @(negedge clk_i);
        check_reset_vals();
        rst_ni = 1'b1;
        @(negedge clk_i);

        // basic run
        va = '{-8'sd5, 8'sd3, 8'sd90, 8'sd12, -8'sd128, 8'sd7, 8'sd89, 8'sd0, 8'sd1, 8'sd2};
        for (int i = 0; i < NC; i++) eng_vals[i] = va[i];
        run_one(50);

        // all minimum values
        for (int i = 0; i < NC; i++) eng_vals[i] = -8'sd128;
        run_one(50);

        // tie at 3 and 7
        for (int i = 0; i < NC; i++) eng_vals[i] = 8'(-100 + i);
        eng_vals[3] = 8'sd40;
        eng_vals[7] = 8'sd40;
        run_one(30);

        // maximum at the last index
        for (int i = 0; i < NC; i++) eng_vals[i] = 8'(i * 3 - 20);
        eng_vals[NC-1] = 8'sd127;
        run_one(5);

        // stale done still high from the previous run
        check_eq("stale_done_pre", eng_done_i, 1);
        rand_vals();
        run_one(1);

        // handshake hold, then ack with req held high
        rand_vals();
        e = model_result();
        sb.push_back(e);
        done_delay = 20;
        pulse_req();
        wait_valid();
        repeat (20) begin
            @(negedge clk_i);
            check_eq("hold_valid", res_valid_o, 1);
            check_eq("hold_digit", res_digit_o, e.digit);
            check_eq("hold_score", res_score_o, e.score);
            check_eq("hold_busy", busy_o, 1);
        end
        sb.push_back(e);
        req_i     = 1'b1;
        res_ack_i = 1'b1;
        @(negedge clk_i);
        res_ack_i = 1'b0;
        check_eq("hs_valid_fall", res_valid_o, 0);
        check_eq("hs_busy_fall", busy_o, 0);
        check_eq("hs_rst_a0", eng_reset_o, 0);
        @(negedge clk_i);
        check_eq("hs_rst_a1", eng_reset_o, 0);
        @(negedge clk_i);
        check_eq("hs_rst_a2", eng_reset_o, 1);
        req_i = 1'b0;
        wait_valid();
        ack_it();

        // reset during SCAN at idx 4
        rand_vals();
        done_delay = 10;
        pulse_req();
        k = 0;
        while (eng_idx_o != 4'd4 && k < 500) begin
            @(negedge clk_i);
            k++;
        end
        check_eq("mid_idx", eng_idx_o, 4);
        rst_ni = 1'b0;
        #1;
        check_reset_vals();
        sb.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (6) begin
            @(negedge clk_i);
            check_eq("post_rst_busy", busy_o, 0);
        end
        check_eq("post_rst_pulses", n_rst_p, 0);

`ifdef DNN_CTRL_TIMEOUT_EN
        never_done = 1'b1;
        e.digit = 4'hF;
        e.score = 8'sd0;
        e.err   = 1'b1;
        sb.push_back(e);
        pulse_req();
        wait_valid();
        c_rise = cyc;
        check_eq("timeout_latency", c_rise - start_cyc, TO);
        ack_it();
        never_done = 1'b0;
        rand_vals();
        run_one(8);
`else
        never_done = 1'b1;
        rand_vals();
        e = model_result();
        sb.push_back(e);
        pulse_req();
        repeat (150) @(negedge clk_i);
        check_eq("no_timeout_valid", res_valid_o, 0);
        check_eq("no_timeout_busy", busy_o, 1);
        never_done = 1'b0;
        kick = 1'b1;
        @(negedge clk_i);
        kick = 1'b0;
        wait_valid();
        c_rise = cyc;
        check_eq("late_done_seen", c_rise > start_cyc + 150, 1);
        ack_it();
`endif

        // random runs
        for (int r = 0; r < 4; r++) begin
            rand_vals();
            run_one($urandom_range(1, 20));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
